// File: rtl/dds_sin_lut.sv
// dds_sin_lut: phase-to-amplitude stage of the DDS. It maps an 8-bit phase
// address to an offset-binary sine sample through a 3-stage pipeline.
// Inputs: clk, rst (async, active high), addr_in/addr_valid (phase),
//   amp_in/amp_we (request a new amplitude).
// Outputs: sin_out/sin_valid (DAC sample), amp_busy (amplitude pending).
module dds_sin_lut #(
  parameter logic [7:0] AMP_RESET  = 8'd255,
  parameter logic [7:0] OUT_OFFSET = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr_in,
  input  logic       addr_valid,
  input  logic [7:0] amp_in,
  input  logic       amp_we,
  output logic [7:0] sin_out,
  output logic       sin_valid,
  output logic       amp_busy
);

  // Quarter-wave table: round(127*sin(2*pi*k/256)), k=0..64.
  function automatic logic [6:0] qtab(input logic [6:0] k);
    logic [6:0] q;
    case (k)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;
      7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd16;
      7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;  7'd9:  q = 7'd28;
      7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;
      7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;
      7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;
      7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;
      7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;
      7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;
      7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100;
      7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107;
      7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113;
      7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118;
      7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122;
      7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125;
      7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126;
      default: q = 7'd127;
    endcase
    return q;
  endfunction

  logic [1:0] quad;
  logic [5:0] idx;
  logic       wrap;
  logic       apply;
  logic [6:0] mag;

  logic       v1_q, v1_d;
  logic [6:0] eff1_q, eff1_d;
  logic       neg1_q, neg1_d;
  logic [7:0] amp1_q, amp1_d;
  logic       v2_q, v2_d;
  logic [7:0] s2_q, s2_d;
  logic [7:0] amp2_q, amp2_d;
  logic       vld_q, vld_d;
  logic [7:0] sin_q, sin_d;
  logic [7:0] act_q, act_d;
  logic [7:0] pend_q, pend_d;
  logic       busy_q, busy_d;
  logic [1:0] prevq_q, prevq_d;

  assign quad = addr_in[7:6];
  assign idx  = addr_in[5:0];

  // Wrap: accepted quadrant-0 sample right after a quadrant-3 sample.
  assign wrap  = addr_valid && (quad == 2'd0)
               && (prevq_q == 2'd3);
  assign apply = wrap && busy_q;

  always_comb begin
    act_d   = apply ? pend_q : act_q;
    pend_d  = amp_we ? amp_in : pend_q;
    busy_d  = amp_we ? 1'b1 : (wrap ? 1'b0 : busy_q);
    prevq_d = addr_valid ? quad : prevq_q;
  end

  // S1: quadrant mirroring and amplitude tag.
  always_comb begin
    v1_d   = addr_valid;
    eff1_d = eff1_q;
    neg1_d = neg1_q;
    amp1_d = amp1_q;
    if (addr_valid) begin
      eff1_d = quad[0] ? (7'd64 - {1'b0, idx})
                       : {1'b0, idx};
      neg1_d = quad[1];
      amp1_d = apply ? pend_q : act_q;
    end
  end

  // S2: table lookup and sign.
  always_comb begin
    mag    = qtab(eff1_q);
    v2_d   = v1_q;
    s2_d   = s2_q;
    amp2_d = amp2_q;
    if (v1_q) begin
      s2_d   = neg1_q ? -{1'b0, mag} : {1'b0, mag};
      amp2_d = amp1_q;
    end
  end

  // S3: signed scale, floor shift, offset.
  // The 16x16 product low half equals the signed 8x9 product.
  always_comb begin
    vld_d = v2_q;
    sin_d = sin_q;
    if (v2_q)
      sin_d = 8'(({{8{s2_q[7]}}, s2_q}
                  * {8'd0, amp2_q}) >> 8)
            + OUT_OFFSET;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      eff1_q  <= '0;
      neg1_q  <= 1'b0;
      amp1_q  <= '0;
      v2_q    <= 1'b0;
      s2_q    <= '0;
      amp2_q  <= '0;
      vld_q   <= 1'b0;
      sin_q   <= OUT_OFFSET;
      act_q   <= AMP_RESET;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      prevq_q <= 2'd3;
    end else begin
      v1_q    <= v1_d;
      eff1_q  <= eff1_d;
      neg1_q  <= neg1_d;
      amp1_q  <= amp1_d;
      v2_q    <= v2_d;
      s2_q    <= s2_d;
      amp2_q  <= amp2_d;
      vld_q   <= vld_d;
      sin_q   <= sin_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      prevq_q <= prevq_d;
    end
  end

  assign sin_out   = sin_q;
  assign sin_valid = vld_q;
  assign amp_busy  = busy_q;

endmodule
